// File: rtl/ps2_scancode_rx_pkg.sv
// Shared definitions for the PS/2 scan-code receiver: frame FSM states,
// frame format constants and default timing parameters.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } ps2_state_e;

    localparam int   PS2_DATA_BITS   = 8;
    localparam logic PS2_START_LEVEL = 1'b0;
    localparam logic PS2_STOP_LEVEL  = 1'b1;
    localparam logic PS2_ODD_PARITY  = 1'b1;

    localparam int DEFAULT_FILTER_LEN  = 8;
    localparam int DEFAULT_TIMEOUT_CYC = 20000;

    // A frame is good when the stop bit is high and data plus parity has an odd number of ones
    function automatic logic frame_ok(input logic [PS2_DATA_BITS-1:0] data,
                                      input logic                     parity,
                                      input logic                     stop);
        return (stop == PS2_STOP_LEVEL) && ((^{data, parity}) == PS2_ODD_PARITY);
    endfunction

endpackage

// File: rtl/ps2_scancode_rx_if.sv
// Bundle of the PS/2 pins and the decoded scan-code outputs. The master side
// is the keyboard/decoder environment, the slave side is the receiver.
interface ps2_scancode_rx_if;
    import ps2_pkg::*;

    logic                         PS2_CLK;
    logic                         PS2_DATA;
    logic [2*PS2_DATA_BITS-1:0]   keycode;
    logic                         oflag;
    logic                         err;

    modport master (
        output PS2_CLK,
        output PS2_DATA,
        input  keycode,
        input  oflag,
        input  err
    );

    modport slave (
        input  PS2_CLK,
        input  PS2_DATA,
        output keycode,
        output oflag,
        output err
    );

endinterface

// File: rtl/ps2_scancode_rx_line_filter.sv
// Two-flop synchroniser followed by a stability filter. The filtered output
// only follows the synchronised line once it has held a new level for
// FILTER_LEN consecutive cycles, so short glitches are swallowed.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic filt
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q,  cnt_d;
    logic          filt_q, filt_d;

    // Count cycles the synchronised line disagrees with the output; adopt it after FILTER_LEN
    always_comb begin
        sync_d = {sync_q[0], raw};
        cnt_d  = '0;
        filt_d = filt_q;
        if (sync_q[1] != filt_q) begin
            if (cnt_q == CW'(FILTER_LEN - 1)) begin
                filt_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchroniser, counter and output registers; idle-high line levels out of reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b11;
            cnt_q  <= '0;
            filt_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign filt = filt_q;

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host receiver. Filters both PS/2 lines, detects falling
// edges of the filtered clock, assembles 11-bit frames and pushes accepted
// bytes into a two-byte history. Bad or stalled frames raise err instead.
module ps2_scancode_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = DEFAULT_FILTER_LEN,
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic             clk,
    input  logic             rst,
    ps2_scancode_rx_if.slave bus
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int BW = $clog2(PS2_DATA_BITS);

    logic clk_filt;
    logic data_filt;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk  (clk),
        .rst  (rst),
        .raw  (bus.PS2_CLK),
        .filt (clk_filt)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk  (clk),
        .rst  (rst),
        .raw  (bus.PS2_DATA),
        .filt (data_filt)
    );

    logic                       clk_prev_q;
    logic                       fall_q, fall_d;
    ps2_state_e                 state_q, state_d;
    logic [BW-1:0]              bit_cnt_q, bit_cnt_d;
    logic [PS2_DATA_BITS-1:0]   shift_q, shift_d;
    logic                       parity_q, parity_d;
    logic [TW-1:0]              tmo_q, tmo_d;
    logic [2*PS2_DATA_BITS-1:0] keycode_q, keycode_d;
    logic                       oflag_q, oflag_d;
    logic                       err_q, err_d;

    assign fall_d = clk_prev_q & ~clk_filt;

    // Frame FSM: a fall always beats a coincident timeout, and err/oflag are mutually exclusive
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        keycode_d = keycode_q;
        oflag_d   = 1'b0;
        err_d     = 1'b0;
        tmo_d     = (state_q == ST_IDLE || fall_q) ? '0 : tmo_q + 1'b1;

        if (fall_q) begin
            case (state_q)
                ST_IDLE: begin
                    if (data_filt == PS2_START_LEVEL) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                        shift_d   = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                ST_DATA: begin
                    shift_d[bit_cnt_q] = data_filt;
                    if (bit_cnt_q == BW'(PS2_DATA_BITS - 1)) begin
                        state_d = ST_PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                ST_PARITY: begin
                    parity_d = data_filt;
                    state_d  = ST_STOP;
                end
                ST_STOP: begin
                    if (frame_ok(shift_q, parity_q, data_filt)) begin
                        keycode_d = {keycode_q[PS2_DATA_BITS-1:0], shift_q};
                        oflag_d   = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else if (state_q != ST_IDLE && tmo_q == TW'(TIMEOUT_CYC - 1)) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            shift_d   = '0;
            parity_d  = 1'b0;
            tmo_d     = '0;
            err_d     = 1'b1;
        end
    end

    // Edge detector, FSM state, timeout counter and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_prev_q <= 1'b1;
            fall_q     <= 1'b0;
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            tmo_q      <= '0;
            keycode_q  <= '0;
            oflag_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            clk_prev_q <= clk_filt;
            fall_q     <= fall_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            tmo_q      <= tmo_d;
            keycode_q  <= keycode_d;
            oflag_q    <= oflag_d;
            err_q      <= err_d;
        end
    end

    assign bus.keycode = keycode_q;
    assign bus.oflag   = oflag_q;
    assign bus.err     = err_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Scoreboard bench for ps2_scancode_rx: frames are bit-banged onto the raw
// PS/2 pins, expected oflag/err events are queued as frames are sent and
// matched against events captured from the DUT outputs.
module tb_ps2_scancode_rx;
    import ps2_pkg::*;

    localparam int FILT = 8;
    localparam int TMO  = 1000;
    localparam int HALF = 20;

    typedef struct packed {
        logic        oflag;
        logic        err;
        logic [15:0] kc;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    ev_t         exp_q[$];
    ev_t         obs_q[$];
    logic [15:0] model_kc = 16'h0000;
    int          compared   = 0;
    int          mismatched = 0;

    ps2_scancode_rx_if bus ();

    ps2_scancode_rx #(
        .FILTER_LEN  (FILT),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running board clock
    always #5 clk = ~clk;

    // Capture every output event away from the active edge
    always @(negedge clk) begin
        if (bus.oflag === 1'b1 || bus.err === 1'b1) begin
            obs_q.push_back('{oflag: bus.oflag, err: bus.err, kc: bus.keycode});
        end
    end

    // Global guard so the run always ends
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation still running, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] b, input logic flip, input logic stop);
        logic par;
        par = ~(^b) ^ flip;
        return {stop, par, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] bits, input int count, input int glitch_at);
        for (int i = 0; i < count; i++) begin
            bus.PS2_DATA = bits[i];
            if (i == glitch_at) begin
                wait_cyc(5);
                bus.PS2_CLK = 1'b0;
                wait_cyc(FILT - 2);
                bus.PS2_CLK = 1'b1;
                wait_cyc(HALF - 5 - (FILT - 2));
            end else begin
                wait_cyc(HALF);
            end
            bus.PS2_CLK = 1'b0;
            wait_cyc(HALF);
            bus.PS2_CLK = 1'b1;
        end
    endtask

    task automatic push_ok(input logic [7:0] b);
        model_kc = {model_kc[7:0], b};
        exp_q.push_back('{oflag: 1'b1, err: 1'b0, kc: model_kc});
    endtask

    task automatic push_err();
        exp_q.push_back('{oflag: 1'b0, err: 1'b1, kc: model_kc});
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.PS2_CLK  = 1'b1;
        bus.PS2_DATA = 1'b1;
        wait_cyc(5);
        compared++;
        if (bus.keycode !== 16'h0000) begin
            mismatched++;
            $display("[TB] FAIL reset_keycode: got %h, required 0000", bus.keycode);
        end
        compared++;
        if (bus.oflag !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_oflag: got %b, required 0", bus.oflag);
        end
        compared++;
        if (bus.err !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_err: got %b, required 0", bus.err);
        end
        rst = 1'b1;
        wait_cyc(5);
    endtask

    task automatic test_single_frame();
        ev_t e, o;
        push_ok(8'h75);
        send_bits(make_frame(8'h75, 1'b0, 1'b1), 11, -1);
        bus.PS2_DATA = 1'b1;
        wait_cyc(40);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            compared++;
            if (obs_q.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL single_frame: no event, required oflag=%b err=%b keycode=%h", e.oflag, e.err, e.kc);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    mismatched++;
                    $display("[TB] FAIL single_frame: got oflag=%b err=%b keycode=%h, required oflag=%b err=%b keycode=%h",
                             o.oflag, o.err, o.kc, e.oflag, e.err, e.kc);
                end
            end
        end
        compared++;
        if (obs_q.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL single_frame_extra: got %0d extra events, required 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_back_to_back();
        ev_t e, o;
        push_ok(8'hF0);
        push_ok(8'h75);
        send_bits(make_frame(8'hF0, 1'b0, 1'b1), 11, -1);
        send_bits(make_frame(8'h75, 1'b0, 1'b1), 11, -1);
        bus.PS2_DATA = 1'b1;
        wait_cyc(40);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            compared++;
            if (obs_q.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL back_to_back: no event, required oflag=%b err=%b keycode=%h", e.oflag, e.err, e.kc);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    mismatched++;
                    $display("[TB] FAIL back_to_back: got oflag=%b err=%b keycode=%h, required oflag=%b err=%b keycode=%h",
                             o.oflag, o.err, o.kc, e.oflag, e.err, e.kc);
                end
            end
        end
        compared++;
        if (obs_q.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL back_to_back_extra: got %0d extra events, required 0", obs_q.size());
            obs_q.delete();
        end
        compared++;
        if (bus.keycode !== 16'hF075) begin
            mismatched++;
            $display("[TB] FAIL back_to_back_keycode: got %h, required F075", bus.keycode);
        end
    endtask

    task automatic test_frame_errors();
        ev_t e, o;
        push_err();
        send_bits(make_frame(8'h6B, 1'b1, 1'b1), 11, -1);
        bus.PS2_DATA = 1'b1;
        wait_cyc(40);
        push_ok(8'h6B);
        send_bits(make_frame(8'h6B, 1'b0, 1'b1), 11, -1);
        bus.PS2_DATA = 1'b1;
        wait_cyc(40);
        push_err();
        send_bits(make_frame(8'h1C, 1'b0, 1'b0), 11, -1);
        bus.PS2_DATA = 1'b1;
        wait_cyc(40);
        push_err();
        send_bits(11'h7FF, 1, -1);
        wait_cyc(40);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            compared++;
            if (obs_q.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL frame_errors: no event, required oflag=%b err=%b keycode=%h", e.oflag, e.err, e.kc);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    mismatched++;
                    $display("[TB] FAIL frame_errors: got oflag=%b err=%b keycode=%h, required oflag=%b err=%b keycode=%h",
                             o.oflag, o.err, o.kc, e.oflag, e.err, e.kc);
                end
            end
        end
        compared++;
        if (obs_q.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL frame_errors_extra: got %0d extra events, required 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_timeout();
        ev_t e, o;
        push_err();
        send_bits(make_frame(8'h29, 1'b0, 1'b1), 6, -1);
        bus.PS2_DATA = 1'b1;
        wait_cyc(TMO + 40);
        compared++;
        if (dut.state_q !== ST_IDLE) begin
            mismatched++;
            $display("[TB] FAIL timeout_state: got %0d, required %0d", dut.state_q, ST_IDLE);
        end
        push_ok(8'h29);
        send_bits(make_frame(8'h29, 1'b0, 1'b1), 11, -1);
        bus.PS2_DATA = 1'b1;
        wait_cyc(40);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            compared++;
            if (obs_q.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL timeout: no event, required oflag=%b err=%b keycode=%h", e.oflag, e.err, e.kc);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    mismatched++;
                    $display("[TB] FAIL timeout: got oflag=%b err=%b keycode=%h, required oflag=%b err=%b keycode=%h",
                             o.oflag, o.err, o.kc, e.oflag, e.err, e.kc);
                end
            end
        end
        compared++;
        if (obs_q.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL timeout_extra: got %0d extra events, required 0", obs_q.size());
            obs_q.delete();
        end
        compared++;
        if (bus.keycode[7:0] !== 8'h29) begin
            mismatched++;
            $display("[TB] FAIL timeout_recover: got %h, required 29", bus.keycode[7:0]);
        end
    endtask

    task automatic test_glitch();
        ev_t e, o;
        push_ok(8'h74);
        send_bits(make_frame(8'h74, 1'b0, 1'b1), 11, 4);
        bus.PS2_DATA = 1'b1;
        wait_cyc(40);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            compared++;
            if (obs_q.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL glitch: no event, required oflag=%b err=%b keycode=%h", e.oflag, e.err, e.kc);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    mismatched++;
                    $display("[TB] FAIL glitch: got oflag=%b err=%b keycode=%h, required oflag=%b err=%b keycode=%h",
                             o.oflag, o.err, o.kc, e.oflag, e.err, e.kc);
                end
            end
        end
        compared++;
        if (obs_q.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL glitch_extra: got %0d extra events, required 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_reset_midframe();
        ev_t e, o;
        send_bits(make_frame(8'h55, 1'b0, 1'b1), 5, -1);
        wait_cyc(15);
        #2;
        rst = 1'b0;
        #1;
        compared++;
        if (bus.keycode !== 16'h0000) begin
            mismatched++;
            $display("[TB] FAIL midreset_keycode: got %h, required 0000", bus.keycode);
        end
        compared++;
        if (bus.oflag !== 1'b0 || bus.err !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL midreset_flags: got oflag=%b err=%b, required 0 0", bus.oflag, bus.err);
        end
        compared++;
        if (dut.state_q !== ST_IDLE) begin
            mismatched++;
            $display("[TB] FAIL midreset_state: got %0d, required %0d", dut.state_q, ST_IDLE);
        end
        bus.PS2_DATA = 1'b1;
        wait_cyc(3);
        rst = 1'b1;
        model_kc = 16'h0000;
        wait_cyc(5);
        push_ok(8'h76);
        send_bits(make_frame(8'h76, 1'b0, 1'b1), 11, -1);
        bus.PS2_DATA = 1'b1;
        wait_cyc(40);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            compared++;
            if (obs_q.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL midreset: no event, required oflag=%b err=%b keycode=%h", e.oflag, e.err, e.kc);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    mismatched++;
                    $display("[TB] FAIL midreset: got oflag=%b err=%b keycode=%h, required oflag=%b err=%b keycode=%h",
                             o.oflag, o.err, o.kc, e.oflag, e.err, e.kc);
                end
            end
        end
        compared++;
        if (obs_q.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL midreset_extra: got %0d extra events, required 0", obs_q.size());
            obs_q.delete();
        end
        compared++;
        if (bus.keycode !== 16'h0076) begin
            mismatched++;
            $display("[TB] FAIL midreset_keycode_after: got %h, required 0076", bus.keycode);
        end
    endtask

    // Run every scenario in order, then report
    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_frame_errors();
        test_timeout();
        test_glitch();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
